// File: rtl/mem_access_ctrl.sv
// Memory-access stage controller: turns EX/MA load/store requests into registered
// data-memory strobes and freezes the pipeline until the access completes or times out.
module mem_access_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MEM_READ,
  input  logic [1:0]  MEM_WRITE,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  input  logic        DMEM_BUSY,
  input  logic [31:0] DMEM_RDATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  output logic [31:0] READ_DATA,
  output logic        STALL,
  output logic        ERR_MISALIGN,
  output logic        ERR_TIMEOUT,
  output logic        ERR_ILLEGAL,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic        ill_q, ill_d;

  logic        req;
  logic        is_write;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Request decode; a store wins over a simultaneous load.
  always_comb begin
    req        = (MEM_READ != 2'b00) || (MEM_WRITE != 2'b00);
    is_write   = (MEM_WRITE != 2'b00);
    size       = is_write ? MEM_WRITE : MEM_READ;
    lane       = ALU_RESULT[1:0];
    misalign   = ((size == SZ_HALF) && lane[0]) ||
                 ((size == SZ_WORD) && (lane != 2'b00));
    wdata_calc = STORE_DATA << {lane, 3'b000};
    case (size)
      SZ_BYTE: be_calc = 4'b0001 << lane;
      SZ_HALF: be_calc = 4'b0011 << lane;
      default: be_calc = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          ill_d = (MEM_READ != 2'b00) && (MEM_WRITE != 2'b00);
          if (misalign) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            rd_d    = ~is_write;
            wr_d    = is_write;
            addr_d  = {ALU_RESULT[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            wait_d  = 4'd0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!DMEM_BUSY) begin
          if (rd_q) rdata_d = DMEM_RDATA;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end else if (wait_q == 4'd15) begin
          // Memory never answered: abandon the access and hand back zero for a load.
          if (rd_q) rdata_d = 32'd0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      ill_q   <= ill_d;
    end
  end

  // STALL is gated by reset so it drops at once even while the request inputs are held.
  assign STALL        = RESET && (((state_q == S_IDLE) && req) || (state_q == S_ACCESS));
  assign DMEM_READ    = rd_q;
  assign DMEM_WRITE   = wr_q;
  assign DMEM_ADDR    = addr_q;
  assign DMEM_BE      = be_q;
  assign DMEM_WDATA   = wdata_q;
  assign READ_DATA    = rdata_q;
  assign ERR_MISALIGN = mis_q;
  assign ERR_TIMEOUT  = to_q;
  assign ERR_ILLEGAL  = ill_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized transactions checked
// against a transaction-level model of stall length, strobes, lanes and error pulses.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  MEM_READ = 2'b00;
  logic [1:0]  MEM_WRITE = 2'b00;
  logic [31:0] ALU_RESULT = 32'd0;
  logic [31:0] STORE_DATA = 32'd0;
  logic        DMEM_BUSY = 1'b0;
  logic [31:0] DMEM_RDATA = 32'd0;
  logic        DMEM_READ, DMEM_WRITE, STALL;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, READ_DATA;
  logic [3:0]  DMEM_BE;
  logic        ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL;
  logic [1:0]  DBG_STATE;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_rd = 32'd0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          stall_cnt;
    int          rd_cyc;
    int          wr_cyc;
    int          mis_cnt;
    int          to_cnt;
    int          ill_cnt;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        held_ok;
    logic        done;
  } obs_t;

  mem_access_ctrl dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .ALU_RESULT(ALU_RESULT), .STORE_DATA(STORE_DATA), .DMEM_BUSY(DMEM_BUSY),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA),
    .READ_DATA(READ_DATA), .STALL(STALL), .ERR_MISALIGN(ERR_MISALIGN),
    .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_ILLEGAL(ERR_ILLEGAL), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  // Transaction-level reference: outcome of one request given a memory that stays busy n cycles.
  function automatic obs_t model(input logic [1:0] rd, input logic [1:0] wr,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input int n, input logic [31:0] rdata,
                                 input logic [31:0] prev);
    obs_t e;
    int   sz, a, acc;
    logic is_wr;
    is_wr = (wr != 0);
    sz    = is_wr ? int'(wr) : int'(rd);
    a     = int'(addr % 4);
    e.ill_cnt = (rd != 0 && wr != 0) ? 1 : 0;
    e.held_ok = 1'b1;
    e.done    = 1'b1;
    e.be = 4'd0; e.addr = 32'd0; e.wdata = 32'd0;
    if ((sz == 2 && (a % 2) != 0) || (sz == 3 && a != 0)) begin
      e.stall_cnt = 1; e.rd_cyc = 0; e.wr_cyc = 0;
      e.mis_cnt = 1; e.to_cnt = 0; e.read_data = prev;
    end else begin
      acc = (n >= 16) ? 16 : n + 1;
      e.stall_cnt = 1 + acc;
      e.rd_cyc  = is_wr ? 0 : acc;
      e.wr_cyc  = is_wr ? acc : 0;
      e.mis_cnt = 0;
      e.to_cnt  = (n >= 16) ? 1 : 0;
      e.be      = (sz == 1) ? 4'((1 << a) % 16) : (sz == 2) ? 4'((3 << a) % 16) : 4'hF;
      e.addr    = addr - 32'(a);
      e.wdata   = sdata * (32'd1 << (8 * a));
      e.read_data = is_wr ? prev : ((n >= 16) ? 32'd0 : rdata);
    end
    return e;
  endfunction

  // Drives one request starting just after a rising edge and records what the DUT did
  // until the first non-stall cycle; returns just after the edge that leaves DONE.
  task automatic run_txn(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input int n, input logic [31:0] rdata, output obs_t o);
    int         acc_seen;
    logic [40:0] first;
    o = '{default: 0};
    o.held_ok = 1'b1;
    acc_seen = 0;
    first = '0;
    MEM_READ = rd; MEM_WRITE = wr; ALU_RESULT = addr; STORE_DATA = sdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      o.mis_cnt += int'(ERR_MISALIGN);
      o.to_cnt  += int'(ERR_TIMEOUT);
      o.ill_cnt += int'(ERR_ILLEGAL);
      if (DMEM_READ || DMEM_WRITE) begin
        if (acc_seen == 0) begin
          first = {DMEM_BE, DMEM_ADDR, DMEM_READ, DMEM_WRITE, 3'b000};
          o.be = DMEM_BE; o.addr = DMEM_ADDR; o.wdata = DMEM_WDATA;
        end else if ({DMEM_BE, DMEM_ADDR, DMEM_READ, DMEM_WRITE, 3'b000} !== first ||
                     DMEM_WDATA !== o.wdata) begin
          o.held_ok = 1'b0;
        end
        o.rd_cyc += int'(DMEM_READ);
        o.wr_cyc += int'(DMEM_WRITE);
        DMEM_BUSY  = (acc_seen < n);
        DMEM_RDATA = DMEM_BUSY ? 32'h0BAD_0BAD : rdata;
        acc_seen++;
      end else begin
        DMEM_BUSY = 1'b0;
      end
      if (STALL) o.stall_cnt++;
      else begin
        o.done = 1'b1;
        o.read_data = READ_DATA;
        break;
      end
    end
    @(posedge CLK); #1;
    MEM_READ = 2'b00; MEM_WRITE = 2'b00; DMEM_BUSY = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    #2;
    n_cmp++;
    if ({DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_BE, DMEM_WDATA, READ_DATA, STALL,
         ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL, DBG_STATE} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    MEM_READ = 2'b11;
    #1;
    n_cmp++;
    if (STALL !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", STALL); end
    MEM_READ = 2'b00;
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++;
    if (STALL !== 1'b0 || DBG_STATE !== 2'd0) begin
      n_fail++; $display("FAIL idle_no_req: got stall=%b state=%0d want 0/0", STALL, DBG_STATE);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_word_load;
    obs_t o;
    run_txn(2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, o);
    run_txn(2'b11, 2'b00, 32'h100, 32'h0, 0, 32'hDEADBEEF, o);
    n_cmp++;
    if (o.stall_cnt != 2) begin n_fail++; $display("FAIL wl_stall: got %0d want 2", o.stall_cnt); end
    n_cmp++;
    if (o.read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wl_rdata: got %h want deadbeef", o.read_data); end
    n_cmp++;
    if (o.be !== 4'b1111 || o.addr !== 32'h100) begin
      n_fail++; $display("FAIL wl_be_addr: got %b/%h want 1111/00000100", o.be, o.addr);
    end
    n_cmp++;
    if (o.rd_cyc != 1 || o.wr_cyc != 0) begin n_fail++; $display("FAIL wl_strobe: got rd=%0d wr=%0d want 1/0", o.rd_cyc, o.wr_cyc); end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_byte_store;
    obs_t o;
    run_txn(2'b00, 2'b01, 32'h103, 32'h000000AB, 0, 32'h0, o);
    n_cmp++;
    if (o.be !== 4'b1000) begin n_fail++; $display("FAIL bs_be: got %b want 1000", o.be); end
    n_cmp++;
    if (o.wdata !== 32'hAB000000) begin n_fail++; $display("FAIL bs_wdata: got %h want ab000000", o.wdata); end
    n_cmp++;
    if (o.wr_cyc != 1 || o.rd_cyc != 0) begin n_fail++; $display("FAIL bs_strobe: got wr=%0d rd=%0d want 1/0", o.wr_cyc, o.rd_cyc); end
    n_cmp++;
    if (o.read_data !== last_rd) begin n_fail++; $display("FAIL bs_rdata_kept: got %h want %h", o.read_data, last_rd); end
  endtask

  task automatic test_misalign;
    obs_t o;
    run_txn(2'b10, 2'b00, 32'h101, 32'h0, 0, 32'h12345678, o);
    n_cmp++;
    if (o.mis_cnt != 1) begin n_fail++; $display("FAIL ma_pulse: got %0d want 1", o.mis_cnt); end
    n_cmp++;
    if (o.rd_cyc != 0 || o.wr_cyc != 0) begin n_fail++; $display("FAIL ma_strobe: got rd=%0d wr=%0d want 0/0", o.rd_cyc, o.wr_cyc); end
    n_cmp++;
    if (o.stall_cnt != 1) begin n_fail++; $display("FAIL ma_stall: got %0d want 1", o.stall_cnt); end
    n_cmp++;
    if (o.read_data !== last_rd) begin n_fail++; $display("FAIL ma_rdata_kept: got %h want %h", o.read_data, last_rd); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_txn(2'b11, 2'b00, 32'h200, 32'h0, 1000, 32'h55555555, o);
    n_cmp++;
    if (o.to_cnt != 1) begin n_fail++; $display("FAIL to_pulse: got %0d want 1", o.to_cnt); end
    n_cmp++;
    if (o.rd_cyc != 16) begin n_fail++; $display("FAIL to_access_cycles: got %0d want 16", o.rd_cyc); end
    n_cmp++;
    if (o.stall_cnt != 17 || !o.done) begin n_fail++; $display("FAIL to_stall: got %0d done=%b want 17/1", o.stall_cnt, o.done); end
    n_cmp++;
    if (o.read_data !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", o.read_data); end
    n_cmp++;
    if (!o.held_ok) begin n_fail++; $display("FAIL to_held: strobes moved while busy, want constant"); end
    last_rd = 32'h0;
  endtask

  task automatic test_illegal;
    obs_t o;
    run_txn(2'b11, 2'b11, 32'h8, 32'hCAFEF00D, 0, 32'h0, o);
    n_cmp++;
    if (o.ill_cnt != 1) begin n_fail++; $display("FAIL il_pulse: got %0d want 1", o.ill_cnt); end
    n_cmp++;
    if (o.wr_cyc != 1 || o.rd_cyc != 0) begin n_fail++; $display("FAIL il_strobe: got wr=%0d rd=%0d want 1/0", o.wr_cyc, o.rd_cyc); end
    n_cmp++;
    if (o.wdata !== 32'hCAFEF00D || o.addr !== 32'h8) begin
      n_fail++; $display("FAIL il_data: got %h@%h want cafef00d@00000008", o.wdata, o.addr);
    end
  endtask

  task automatic test_reset_in_access;
    MEM_READ = 2'b11; ALU_RESULT = 32'h40; DMEM_BUSY = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    n_cmp++;
    if (DMEM_READ !== 1'b1 || STALL !== 1'b1) begin
      n_fail++; $display("FAIL ra_busy: got rd=%b stall=%b want 1/1", DMEM_READ, STALL);
    end
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (DMEM_READ !== 1'b0 || DMEM_WRITE !== 1'b0 || STALL !== 1'b0 || DMEM_ADDR !== 32'h0) begin
      n_fail++; $display("FAIL ra_drop: got rd=%b wr=%b stall=%b addr=%h want 0", DMEM_READ, DMEM_WRITE, STALL, DMEM_ADDR);
    end
    MEM_READ = 2'b00; DMEM_BUSY = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (DBG_STATE !== 2'd0 || DMEM_READ !== 1'b0 || STALL !== 1'b0) begin
      n_fail++; $display("FAIL ra_release: got state=%0d rd=%b stall=%b want 0/0/0", DBG_STATE, DMEM_READ, STALL);
    end
    last_rd = 32'h0;
    @(posedge CLK); #1;
  endtask

  task automatic test_random;
    obs_t o, e;
    logic [1:0]  rd, wr;
    logic [31:0] addr, sdata, rdata, got_rd;
    int          n, gap;
    for (int t = 0; t < 60; t++) begin
      rd = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if (rd == 0 && wr == 0) rd = 2'($urandom_range(1, 3));
      addr  = {20'h0, 12'($urandom)};
      sdata = $urandom;
      rdata = $urandom;
      n     = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 4);
      e = model(rd, wr, addr, sdata, n, rdata, last_rd);
      exp_q.push_back(e.read_data);
      run_txn(rd, wr, addr, sdata, n, rdata, o);
      got_rd = exp_q.pop_front();
      n_cmp++;
      if (o.stall_cnt != e.stall_cnt || !o.done) begin
        n_fail++; $display("FAIL rnd%0d_stall: got %0d want %0d", t, o.stall_cnt, e.stall_cnt);
      end
      n_cmp++;
      if (o.rd_cyc != e.rd_cyc || o.wr_cyc != e.wr_cyc) begin
        n_fail++; $display("FAIL rnd%0d_strobes: got rd=%0d wr=%0d want %0d/%0d", t, o.rd_cyc, o.wr_cyc, e.rd_cyc, e.wr_cyc);
      end
      n_cmp++;
      if (o.mis_cnt != e.mis_cnt || o.to_cnt != e.to_cnt || o.ill_cnt != e.ill_cnt) begin
        n_fail++; $display("FAIL rnd%0d_errs: got m%0d t%0d i%0d want m%0d t%0d i%0d", t,
                           o.mis_cnt, o.to_cnt, o.ill_cnt, e.mis_cnt, e.to_cnt, e.ill_cnt);
      end
      n_cmp++;
      if (o.read_data !== got_rd) begin
        n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", t, o.read_data, got_rd);
      end
      n_cmp++;
      if (!o.held_ok) begin n_fail++; $display("FAIL rnd%0d_held: strobes moved while busy", t); end
      if (e.mis_cnt == 0) begin
        n_cmp++;
        if (o.be !== e.be || o.addr !== e.addr || o.wdata !== e.wdata) begin
          n_fail++; $display("FAIL rnd%0d_lanes: got %b %h %h want %b %h %h", t,
                             o.be, o.addr, o.wdata, e.be, e.addr, e.wdata);
        end
      end
      last_rd = e.read_data;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        n_cmp++;
        if (STALL !== 1'b0 || DBG_STATE !== 2'd0) begin
          n_fail++; $display("FAIL rnd%0d_idle: got stall=%b state=%0d want 0/0", t, STALL, DBG_STATE);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misalign();
    test_timeout();
    test_illegal();
    test_reset_in_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
